// File: rtl/fp_addsub_issuer_if.sv
// Request, unit and response channels of fp_addsub_issuer bundled in one interface.
// slave is the issuer's view, master is the view of whatever drives requests and models the unit.
interface fp_addsub_issuer_if #(
    parameter int TAG_W = 4
);
    // valid/ready: a transfer happens on a rising edge where valid && ready are both high;
    // once valid is raised, the payload stays stable and valid stays high until that edge.
    logic             req_valid;
    logic             req_ready;
    logic             req_mode;
    logic [31:0]      req_op1;
    logic [31:0]      req_op2;
    logic [TAG_W-1:0] req_tag;

    logic             add_start;
    logic             mode;
    logic [31:0]      op1;
    logic [31:0]      op2;
    logic             add_done;
    logic [31:0]      add_result;
    logic             add_overflow;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic             rsp_overflow;
    logic             rsp_timeout;
    logic [TAG_W-1:0] rsp_tag;

    modport slave (
        input  req_valid, req_mode, req_op1, req_op2, req_tag,
        input  add_done, add_result, add_overflow,
        input  rsp_ready,
        output req_ready,
        output add_start, mode, op1, op2,
        output rsp_valid, rsp_result, rsp_overflow, rsp_timeout, rsp_tag
    );

    modport master (
        output req_valid, req_mode, req_op1, req_op2, req_tag,
        output add_done, add_result, add_overflow,
        output rsp_ready,
        input  req_ready,
        input  add_start, mode, op1, op2,
        input  rsp_valid, rsp_result, rsp_overflow, rsp_timeout, rsp_tag
    );
endinterface

// File: rtl/fp_addsub_issuer.sv
// Single-outstanding front end for the FP add/sub unit with a done watchdog.
// Optional FP_ZERO_BYPASS_EN answers requests with a +-0 operand directly, without the unit.
module fp_addsub_issuer #(
    parameter int TAG_W          = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic                clk,
    input  logic                rst,
    fp_addsub_issuer_if.slave   bus,
    output logic [1:0]          state_dbg
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [31:0]      TIMEOUT_NAN = 32'h7FC0_0000;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state;
    logic             mode_q;
    logic [31:0]      op1_q;
    logic [31:0]      op2_q;
    logic [TAG_W-1:0] tag_q;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      rsp_result_q;
    logic             rsp_overflow_q;
    logic             rsp_timeout_q;

    logic             bypass;
    logic [31:0]      bypass_result;

`ifdef FP_ZERO_BYPASS_EN
    logic op1_zero;
    logic op2_zero;

    // +-0 means exponent and fraction both zero; the sign bit is ignored.
    assign op1_zero      = (bus.req_op1[30:0] == 31'd0);
    assign op2_zero      = (bus.req_op2[30:0] == 31'd0);
    assign bypass        = op1_zero || op2_zero;
    assign bypass_result = op2_zero ? bus.req_op1
                                    : {bus.req_op2[31] ^ bus.req_mode, bus.req_op2[30:0]};
`else
    assign bypass        = 1'b0;
    assign bypass_result = 32'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            mode_q         <= 1'b0;
            op1_q          <= 32'd0;
            op2_q          <= 32'd0;
            tag_q          <= '0;
            cnt            <= '0;
            rsp_result_q   <= 32'd0;
            rsp_overflow_q <= 1'b0;
            rsp_timeout_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        mode_q <= bus.req_mode;
                        op1_q  <= bus.req_op1;
                        op2_q  <= bus.req_op2;
                        tag_q  <= bus.req_tag;
                        if (bypass) begin
                            rsp_result_q   <= bypass_result;
                            rsp_overflow_q <= 1'b0;
                            rsp_timeout_q  <= 1'b0;
                            state          <= S_RESP;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // A done arriving on the last watchdog cycle still wins.
                    if (bus.add_done) begin
                        rsp_result_q   <= bus.add_result;
                        rsp_overflow_q <= bus.add_overflow;
                        rsp_timeout_q  <= 1'b0;
                        state          <= S_RESP;
                    end else if (cnt == CNT_LAST) begin
                        rsp_result_q   <= TIMEOUT_NAN;
                        rsp_overflow_q <= 1'b0;
                        rsp_timeout_q  <= 1'b1;
                        state          <= S_RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready    = (state == S_IDLE);
    assign bus.add_start    = (state == S_ISSUE);
    assign bus.mode         = mode_q;
    assign bus.op1          = op1_q;
    assign bus.op2          = op2_q;

    assign bus.rsp_valid    = (state == S_RESP);
    assign bus.rsp_result   = rsp_result_q;
    assign bus.rsp_overflow = rsp_overflow_q;
    assign bus.rsp_timeout  = rsp_timeout_q;
    assign bus.rsp_tag      = tag_q;

    assign state_dbg        = state;

endmodule

// File: tb/tb_fp_addsub_issuer.sv
// Bench for fp_addsub_issuer: vector table, hand sequences and random ops against a reference model.
// Build with FP_ZERO_BYPASS_EN defined to exercise the zero bypass expectations.
module tb_fp_addsub_issuer;

    localparam int TAG_W = 4;
    localparam int TO    = 16;
    localparam int CNT_W = 8;
    localparam int W     = 32 + 1 + 1 + TAG_W;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] state_dbg;

    int checks      = 0;
    int errors      = 0;
    int cyc         = 0;
    int model_k     = 1;
    int start_count = 0;
    logic        model_override = 1'b0;
    logic [31:0] override_res   = 32'd0;
    logic        late_pulse     = 1'b0;

    logic [W-1:0] exp_q[$];

    fp_addsub_issuer_if #(.TAG_W(TAG_W)) bus();

    fp_addsub_issuer #(
        .TAG_W(TAG_W),
        .TIMEOUT_CYCLES(TO),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .state_dbg(state_dbg)
    );

    // clock / cycle counter / global time limit
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL global_time_limit: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "time limit");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Stand-in arithmetic for the unit: any deterministic function of the forwarded operands.
    function automatic logic [32:0] fake_unit(input logic m, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        r = m ? (a - b) : (a + b);
        return {r[31] ^ r[0], r};
    endfunction

    function automatic void ref_model(input logic m, input logic [31:0] a, input logic [31:0] b,
                                      input int k, output logic [31:0] r, output logic ovf,
                                      output logic tmo, output int lat, output int starts);
        logic [32:0] u;
        bit byp;
        byp = 1'b0;
`ifdef FP_ZERO_BYPASS_EN
        byp = (a[30:0] == 31'd0) || (b[30:0] == 31'd0);
`endif
        if (byp) begin
            starts = 0;
            lat    = 1;
            ovf    = 1'b0;
            tmo    = 1'b0;
            r      = (b[30:0] == 31'd0) ? a : {b[31] ^ m, b[30:0]};
        end else if (k < 1 || k > TO) begin
            starts = 1;
            lat    = TO + 2;
            ovf    = 1'b0;
            tmo    = 1'b1;
            r      = 32'h7FC0_0000;
        end else begin
            u      = fake_unit(m, a, b);
            starts = 1;
            lat    = k + 2;
            ovf    = u[32];
            tmo    = 1'b0;
            r      = u[31:0];
        end
    endfunction

    // Unit model: answers k cycles after add_start (k == 0 never answers), checks operand hold.
    initial begin : unit_model
        logic        busy;
        logic        prev_start;
        logic        cm;
        logic [31:0] c1;
        logic [31:0] c2;
        logic [32:0] r;
        int          n;
        int          mk;
        busy = 1'b0; prev_start = 1'b0; cm = 1'b0; c1 = 32'd0; c2 = 32'd0; n = 0; mk = 0;
        bus.add_done = 1'b0; bus.add_result = 32'd0; bus.add_overflow = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.add_done = 1'b0;
            if (rst) busy = 1'b0;
            if (late_pulse) begin
                bus.add_done     = 1'b1;
                bus.add_result   = 32'hDEAD_BEEF;
                bus.add_overflow = 1'b1;
                late_pulse       = 1'b0;
            end
            if (busy) begin
                n++;
                if (n <= TO) begin
                    check("op1_hold", bus.op1, c1);
                    check("op2_hold", bus.op2, c2);
                    check("mode_hold", bus.mode, cm);
                end
                if (n == mk) begin
                    r = model_override ? {1'b0, override_res} : fake_unit(cm, c1, c2);
                    bus.add_done     = 1'b1;
                    bus.add_result   = r[31:0];
                    bus.add_overflow = r[32];
                    busy             = 1'b0;
                end
            end
            if (bus.add_start) begin
                start_count++;
                check("start_pulse_width", prev_start, 1'b0);
                mk   = model_k;
                busy = (mk > 0);
                n    = 0;
                c1   = bus.op1;
                c2   = bus.op2;
                cm   = bus.mode;
            end
            prev_start = bus.add_start;
        end
    end

    // driver tasks
    task automatic send_req(input logic m, input logic [31:0] a, input logic [31:0] b,
                            input logic [TAG_W-1:0] t, output int acc, output bit ok);
        bus.req_valid = 1'b1; bus.req_mode = m; bus.req_op1 = a; bus.req_op2 = b; bus.req_tag = t;
        ok = 1'b0; acc = 0;
        for (int i = 0; i < 60; i++) begin
            if (bus.req_ready) begin
                acc = cyc; ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("req_accept_wait", bus.req_ready, 1'b1);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int at, output bit ok);
        ok = 1'b0; at = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.rsp_valid) begin
                at = cyc; ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
        check("rsp_wait", bus.rsp_valid, 1'b1);
    endtask

    task automatic handshake(input string name);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check({name, " rsp_valid_drop"}, bus.rsp_valid, 1'b0);
        check({name, " req_ready_back"}, bus.req_ready, 1'b1);
    endtask

    task automatic check_idle(input string name);
        check({name, " add_start"}, bus.add_start, 1'b0);
        check({name, " mode"}, bus.mode, 1'b0);
        check({name, " op1"}, bus.op1, 32'd0);
        check({name, " op2"}, bus.op2, 32'd0);
        check({name, " rsp_valid"}, bus.rsp_valid, 1'b0);
        check({name, " rsp_result"}, bus.rsp_result, 32'd0);
        check({name, " rsp_overflow"}, bus.rsp_overflow, 1'b0);
        check({name, " rsp_timeout"}, bus.rsp_timeout, 1'b0);
        check({name, " rsp_tag"}, bus.rsp_tag, '0);
        check({name, " req_ready"}, bus.req_ready, 1'b1);
    endtask

    task automatic run_op(input string name, input logic m, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] t, input int k, input int bp,
                          input logic [31:0] er, input logic eo, input logic et,
                          input int elat, input int estarts);
        int           acc;
        int           rc;
        int           sc0;
        bit           ok;
        logic [W-1:0] got;
        logic [W-1:0] exp;
        model_k = k;
        sc0     = start_count;
        exp_q.push_back({er, eo, et, t});
        send_req(m, a, b, t, acc, ok);
        wait_rsp(rc, ok);
        exp = exp_q.pop_front();
        if (!ok) return;
        check({name, " latency"}, rc - acc, elat);
        got = {bus.rsp_result, bus.rsp_overflow, bus.rsp_timeout, bus.rsp_tag};
        check({name, " rsp"}, got, exp);
        check({name, " starts"}, start_count - sc0, estarts);
        repeat (bp) @(negedge clk);
        handshake(name);
    endtask

    typedef struct {
        logic             m;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] t;
        int               k;
        logic [31:0]      er;
        logic             eo;
        logic             et;
        int               elat;
        int               starts;
    } vec_t;

    vec_t vecs[10];

    initial begin : main
        int           acc;
        int           rc;
        bit           ok;
        bit           seen;
        logic [W-1:0] snap;
        logic [W-1:0] exp;

        vecs[0] = '{1'b0, 32'h3F80_0000, 32'h4000_0000, 4'h0, 1,  32'h7F80_0000, 1'b0, 1'b0, 3,  1};
        vecs[1] = '{1'b1, 32'h4040_0000, 32'h3F80_0000, 4'h1, 2,  32'h00C0_0000, 1'b0, 1'b0, 4,  1};
        vecs[2] = '{1'b0, 32'h40A0_0000, 32'h0000_0001, 4'h2, 7,  32'h40A0_0001, 1'b1, 1'b0, 9,  1};
`ifdef FP_ZERO_BYPASS_EN
        vecs[3] = '{1'b1, 32'h41C4_0000, 32'h0000_0000, 4'h3, 3,  32'h41C4_0000, 1'b0, 1'b0, 1,  0};
        vecs[4] = '{1'b1, 32'h8000_0000, 32'h4242_0000, 4'h4, 2,  32'hC242_0000, 1'b0, 1'b0, 1,  0};
        vecs[5] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 4'h5, 1,  32'h8000_0000, 1'b0, 1'b0, 1,  0};
        vecs[6] = '{1'b0, 32'h0000_0000, 32'hBF80_0000, 4'h6, 4,  32'hBF80_0000, 1'b0, 1'b0, 1,  0};
`else
        vecs[3] = '{1'b1, 32'h41C4_0000, 32'h0000_0000, 4'h3, 3,  32'h41C4_0000, 1'b0, 1'b0, 5,  1};
        vecs[4] = '{1'b1, 32'h8000_0000, 32'h4242_0000, 4'h4, 2,  32'h3DBE_0000, 1'b0, 1'b0, 4,  1};
        vecs[5] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 4'h5, 1,  32'h0000_0000, 1'b0, 1'b0, 3,  1};
        vecs[6] = '{1'b0, 32'h0000_0000, 32'hBF80_0000, 4'h6, 4,  32'hBF80_0000, 1'b1, 1'b0, 6,  1};
`endif
        vecs[7] = '{1'b1, 32'h1234_5678, 32'h0000_0001, 4'h7, 16, 32'h1234_5677, 1'b1, 1'b0, 18, 1};
        vecs[8] = '{1'b0, 32'h3F80_0000, 32'h3F80_0000, 4'h8, 0,  32'h7FC0_0000, 1'b0, 1'b1, 18, 1};
        vecs[9] = '{1'b1, 32'h1111_1111, 32'h2222_2222, 4'h9, 17, 32'h7FC0_0000, 1'b0, 1'b1, 18, 1};

        bus.req_valid = 1'b0; bus.req_mode = 1'b0; bus.req_op1 = 32'd0; bus.req_op2 = 32'd0;
        bus.req_tag = '0; bus.rsp_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_idle("reset");

        // basic add with a fixed unit answer after k = 3
        model_override = 1'b1;
        override_res   = 32'h4187_3333;
        run_op("basic", 1'b0, 32'h4104_0000, 32'h410A_6666, 4'h3, 3, 0,
               32'h4187_3333, 1'b0, 1'b0, 5, 1);
        model_override = 1'b0;

        // back-pressure: response held 5 cycles while a new request waits
        model_k = 2;
        exp_q.push_back({32'h8077_082F, 1'b0, 1'b0, 4'hA});
        send_req(1'b0, 32'h4049_0FDB, 32'h402D_F854, 4'hA, acc, ok);
        wait_rsp(rc, ok);
        snap = {bus.rsp_result, bus.rsp_overflow, bus.rsp_timeout, bus.rsp_tag};
        exp  = exp_q.pop_front();
        check("bp rsp", snap, exp);
        bus.req_valid = 1'b1; bus.req_mode = 1'b1;
        bus.req_op1 = 32'h3F80_0000; bus.req_op2 = 32'h3F80_0000; bus.req_tag = 4'hB;
        model_k = 1;
        for (int i = 0; i < 5; i++) begin
            check("bp hold", {bus.rsp_valid, bus.rsp_result, bus.rsp_overflow, bus.rsp_timeout, bus.rsp_tag},
                  {1'b1, snap});
            check("bp req_ready_low", bus.req_ready, 1'b0);
            @(negedge clk);
        end
        handshake("bp");
        acc = cyc;
        @(negedge clk);
        bus.req_valid = 1'b0;
        exp_q.push_back({32'h0000_0000, 1'b0, 1'b0, 4'hB});
        wait_rsp(rc, ok);
        exp = exp_q.pop_front();
        check("bp next latency", rc - acc, 3);
        check("bp next rsp", {bus.rsp_result, bus.rsp_overflow, bus.rsp_timeout, bus.rsp_tag}, exp);
        handshake("bp next");

        // vector table
        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].m, vecs[i].a, vecs[i].b, vecs[i].t, vecs[i].k,
                   i % 3, vecs[i].er, vecs[i].eo, vecs[i].et, vecs[i].elat, vecs[i].starts);
        end

        // reset in the middle of WAIT, then a stray done
        model_k = 0;
        send_req(1'b1, 32'h4000_0000, 32'h3F80_0000, 4'h5, acc, ok);
        repeat (4) @(negedge clk);
        check("pre_reset busy", bus.req_ready, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("mid_wait_reset");
        late_pulse = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen = seen | bus.rsp_valid;
        end
        check("late_done ignored", seen, 1'b0);

        // random operations against the reference model
        for (int i = 0; i < 30; i++) begin
            logic             m;
            logic             s;
            logic [31:0]      a;
            logic [31:0]      b;
            logic [TAG_W-1:0] t;
            logic [31:0]      er;
            logic             eo;
            logic             et;
            int               k;
            int               bp;
            int               elat;
            int               st;
            m = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) a = {s, 31'd0};
            if ($urandom_range(0, 3) == 0) b = {~s, 31'd0};
            t  = TAG_W'($urandom);
            k  = $urandom_range(0, TO + 3);
            bp = $urandom_range(0, 3);
            ref_model(m, a, b, k, er, eo, et, elat, st);
            run_op($sformatf("rand%0d", i), m, a, b, t, k, bp, er, eo, et, elat, st);
        end

        check("scoreboard drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
